// File: rtl/rf_pkg.sv
// Shared constants and the byte-merge helper used by both the write path and
// the same-cycle bypass path of register_file_sb.
package rf_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int NUM_RD_DEF   = 2;
  // Widest register the helper handles; callers zero-extend and truncate.
  localparam int MAX_W        = 256;

  function automatic logic [MAX_W-1:0] merge_bytes(
    input logic [MAX_W-1:0]   old_v,
    input logic [MAX_W-1:0]   new_v,
    input logic [MAX_W/8-1:0] be
  );
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W/8; i++)
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// Decode/writeback bus of the register file: write, read ports and issue.
interface register_file_sb_if #(
  parameter int DATA_W   = rf_pkg::DATA_W_DEF,
  parameter int NUM_REGS = rf_pkg::NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = rf_pkg::NUM_RD_DEF
);
  logic                     RegWrite;
  logic [ADDR_W-1:0]        WriteRegister;
  logic [DATA_W-1:0]        WriteData;
  logic [DATA_W/8-1:0]      ByteEn;
  logic [NUM_RD*ADDR_W-1:0] ReadRegister;
  logic [NUM_RD*DATA_W-1:0] ReadData;
  logic [NUM_RD-1:0]        ReadBusy;
  logic                     IssueValid;
  logic [ADDR_W-1:0]        IssueDest;
  logic                     AnyBusy;

  modport master (
    output RegWrite, WriteRegister, WriteData, ByteEn, ReadRegister,
           IssueValid, IssueDest,
    input  ReadData, ReadBusy, AnyBusy
  );
  modport slave (
    input  RegWrite, WriteRegister, WriteData, ByteEn, ReadRegister,
           IssueValid, IssueDest,
    output ReadData, ReadBusy, AnyBusy
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: issue sets, writeback clears, a new producer wins ties.
module rf_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                i_set,
  input  logic [ADDR_W-1:0]   i_set_idx,
  input  logic                i_clr,
  input  logic [ADDR_W-1:0]   i_clr_idx,
  output logic [NUM_REGS-1:0] o_busy,
  output logic                o_any_busy
);

  logic [NUM_REGS-1:0] r_busy;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_set && i_set_idx == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0))
          r_busy[i] <= 1'b1;
        else if (i_clr && i_clr_idx == ADDR_W'(i))
          r_busy[i] <= 1'b0;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_any_busy = |r_busy;

endmodule

// File: rtl/register_file_sb.sv
// Byte-enabled register file with per-port write bypass and a RAW scoreboard.
module register_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                Clk,
  input  logic                Rst_n,
  register_file_sb_if.slave   bus
);

  logic [DATA_W-1:0]              r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]            w_busy;
  logic                           w_any_busy;
  logic                           w_wr_en;
  logic [DATA_W-1:0]              w_wr_merged;
  logic [NUM_RD-1:0][DATA_W-1:0]  w_rd_data;
  logic [NUM_RD-1:0]              w_rd_busy;

  assign w_wr_en = bus.RegWrite &&
                   !(ZERO_REG != 0 && bus.WriteRegister == '0);
  assign w_wr_merged = DATA_W'(merge_bytes(MAX_W'(r_regs[bus.WriteRegister]),
                                           MAX_W'(bus.WriteData),
                                           (MAX_W/8)'(bus.ByteEn)));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        if (w_wr_en && bus.WriteRegister == ADDR_W'(r))
          r_regs[r] <= w_wr_merged;
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .i_set      (bus.IssueValid),
    .i_set_idx  (bus.IssueDest),
    .i_clr      (bus.RegWrite),
    .i_clr_idx  (bus.WriteRegister),
    .o_busy     (w_busy),
    .o_any_busy (w_any_busy)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_idx;
    logic              w_match;
    logic              w_zero;
    assign w_idx   = bus.ReadRegister[k*ADDR_W +: ADDR_W];
    assign w_match = bus.RegWrite && bus.WriteRegister == w_idx;
    assign w_zero  = ZERO_REG != 0 && w_idx == '0;
    // Outputs are forced low during reset so a stray write can't bypass through.
    assign w_rd_data[k] = (!Rst_n || w_zero) ? '0 :
                          w_match ? w_wr_merged : r_regs[w_idx];
    assign w_rd_busy[k] = Rst_n && !w_zero && w_busy[w_idx] && !w_match;
  end

  assign bus.ReadData = w_rd_data;
  assign bus.ReadBusy = w_rd_busy;
  assign bus.AnyBusy  = Rst_n && w_any_busy;

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard-driven bench for register_file_sb (32x32, two read ports).
module tb_register_file_sb;
  import rf_pkg::*;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  register_file_sb_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) bus ();

  register_file_sb #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(1)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // sel: 0/1 ReadData port, 2/3 ReadBusy port, 4 AnyBusy
  task automatic push(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = v;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sel)
        0:       obs = bus.ReadData[31:0];
        1:       obs = bus.ReadData[63:32];
        2:       obs = 32'(bus.ReadBusy[0]);
        3:       obs = 32'(bus.ReadBusy[1]);
        default: obs = 32'(bus.AnyBusy);
      endcase
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk); #1;
    bus.RegWrite = 1'b0;
    bus.IssueValid = 1'b0;
  endtask

  task automatic sample();
    @(negedge Clk);
    drain();
  endtask

  task automatic rd(input int a, input int b);
    bus.ReadRegister = {5'(b), 5'(a)};
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    bus.RegWrite = 1'b1;
    bus.WriteRegister = 5'(a);
    bus.WriteData = d;
    bus.ByteEn = be;
  endtask

  task automatic iss(input int a);
    bus.IssueValid = 1'b1;
    bus.IssueDest = 5'(a);
  endtask

  initial begin
    bus.RegWrite = 0; bus.WriteRegister = 0; bus.WriteData = 0; bus.ByteEn = 0;
    bus.ReadRegister = 0; bus.IssueValid = 0; bus.IssueDest = 0;

    // reset held for two cycles
    rd(8, 25);
    push("rst_rd0", 0, 0); push("rst_rd1", 1, 0);
    push("rst_bz0", 2, 0); push("rst_bz1", 3, 0); push("rst_any", 4, 0);
    sample();
    @(posedge Clk); @(posedge Clk); #1 Rst_n = 1'b1;

    for (int n = 8; n <= 25; n++) begin
      cyc(); wr(n, 32'h100 + 32'(n), 4'hF);
    end
    cyc(); wr(0, 32'hDEADBEEF, 4'hF);
    cyc();
    for (int n = 8; n < 25; n += 2) begin
      rd(n, n + 1);
      push($sformatf("rd%0d", n), 0, 32'h100 + 32'(n));
      push($sformatf("rd%0d", n + 1), 1, 32'h101 + 32'(n));
      push("rd_bz0", 2, 0); push("rd_bz1", 3, 0);
      sample(); cyc();
    end
    rd(0, 0);
    push("zero_rd0", 0, 0); push("zero_rd1", 1, 0);
    sample();

    // bypass merge
    cyc(); wr(10, 32'h11223344, 4'hF);
    cyc(); wr(10, 32'hAABBCCDD, 4'b0101); rd(10, 11);
    push("byp_rd0", 0, 32'h11BB33DD); push("byp_rd1", 1, 32'h10B);
    sample();
    cyc();
    push("byp_store", 0, 32'h11BB33DD);
    sample();

    // scoreboard set / clear
    cyc(); iss(12); rd(12, 12);
    push("iss_pre_bz", 2, 0); push("iss_pre_any", 4, 0);
    sample();
    cyc();
    push("iss_bz0", 2, 1); push("iss_bz1", 3, 1); push("iss_any", 4, 1);
    sample();
    cyc(); wr(12, 32'h55, 4'hF);
    push("wb_bz0", 2, 0); push("wb_rd0", 0, 32'h55); push("wb_bz1", 3, 0);
    push("wb_any", 4, 1);
    sample();
    cyc();
    push("clr_bz0", 2, 0); push("clr_any", 4, 0); push("clr_rd0", 0, 32'h55);
    sample();

    // simultaneous issue and write on a busy register: set wins
    cyc(); iss(12);
    cyc(); iss(12); wr(12, 32'h66, 4'hF);
    push("sim_bz0", 2, 0); push("sim_any", 4, 1);
    sample();
    cyc();
    push("sim_post_bz0", 2, 1); push("sim_post_any", 4, 1);
    push("sim_post_rd0", 0, 32'h66);
    sample();
    // issue to r0 ignored; empty ByteEn still clears busy without data change
    cyc(); iss(0); wr(12, 32'hFFFFFFFF, 4'h0); rd(12, 0);
    push("be0_rd0", 0, 32'h66); push("be0_bz0", 2, 0);
    sample();
    cyc();
    push("be0_post_bz0", 2, 0); push("be0_post_bz1", 3, 0);
    push("be0_post_any", 4, 0); push("be0_post_rd1", 1, 0);
    push("be0_post_rd0", 0, 32'h66);
    sample();

    // async reset mid-stream
    cyc(); iss(12);
    cyc(); rd(12, 9);
    push("pre_rst_bz0", 2, 1); push("pre_rst_any", 4, 1);
    push("pre_rst_rd1", 1, 32'h109);
    sample();
    @(posedge Clk); #1;
    wr(9, 32'hCAFEF00D, 4'hF); iss(13);
    #1 Rst_n = 1'b0;
    #1;
    push("arst_rd0", 0, 0); push("arst_rd1", 1, 0);
    push("arst_bz0", 2, 0); push("arst_any", 4, 0);
    drain();
    #1 Rst_n = 1'b1; bus.RegWrite = 1'b0; bus.IssueValid = 1'b0;
    cyc();
    for (int n = 8; n < 25; n += 2) begin
      rd(n, n + 1);
      push($sformatf("post_rst_rd%0d", n), 0, 0);
      push($sformatf("post_rst_rd%0d", n + 1), 1, 0);
      push("post_rst_any", 4, 0);
      sample(); cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
